// File: rtl/line_mem_responder_pkg.sv
// Shared encodings for the cache-to-memory line interface: FSM states, op codes
// and a constant-width helper used by the responder and its latency counter.
package line_mem_responder_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int ADDR_W = 32;

  // Ceiling log2; returns 0 for a value of 1 so single-entry widths stay legal.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_delay_counter.sv
// Loadable down-counter with a terminal-count flag, used to model fixed memory latency.
module mem_delay_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/line_mem_responder.sv
// Backing line memory below the cache: services one whole-line read or write at a
// time after a fixed latency, returning read data as a one-cycle valid pulse.
//
// state   | meaning
// IDLE    | ready for a request (mem_ready high)
// BUSY    | request latched, latency counter running
// RESPOND | dout holds read data, is_output_valid high for one cycle
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_BLOCKS = 16384,
  parameter int DELAY      = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
);

  localparam int DATA_W  = BLOCK_SIZE * 8;
  localparam int INDEX_W = clog2(NUM_BLOCKS);
  localparam int CNT_W   = clog2(DELAY) + 1;

  logic [1:0]         state_q;
  logic [INDEX_W-1:0] index_q;
  logic [DATA_W-1:0]  din_q;
  logic               op_q;
  logic [DATA_W-1:0]  mem_array [NUM_BLOCKS];

  logic               accept;
  logic               finish;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [CNT_W-1:0]   cnt_value;
  logic               unused_bits;

  // Upper address bits are dropped so line addresses wrap modulo NUM_BLOCKS.
  assign unused_bits = ^{addr[ADDR_W-1:INDEX_W], cnt_value};

  assign accept  = (state_q == ST_IDLE) && is_input_valid && (mem_read || mem_write);
  assign cnt_dec = (state_q == ST_BUSY);
  assign finish  = (state_q == ST_BUSY) && cnt_zero;

  assign mem_ready       = (state_q == ST_IDLE);
  assign is_output_valid = (state_q == ST_RESPOND);

  mem_delay_counter #(
    .WIDTH (CNT_W)
  ) u_delay (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_value (CNT_W'(DELAY - 1)),
    .dec        (cnt_dec),
    .count      (cnt_value),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      din_q   <= '0;
      op_q    <= OP_READ;
      dout    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            index_q <= addr[INDEX_W-1:0];
            din_q   <= din;
            op_q    <= mem_write ? OP_WRITE : OP_READ;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_zero) begin
            if (op_q == OP_WRITE) begin
              state_q <= ST_IDLE;
            end else begin
              dout    <= mem_array[index_q];
              state_q <= ST_RESPOND;
            end
          end
        end
        ST_RESPOND: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  // Storage has no reset: an async reset only aborts the in-flight request.
  always_ff @(posedge clk) begin
    if (finish && (op_q == OP_WRITE)) begin
      mem_array[index_q] <= din_q;
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: vector table plus hand-written
// timing, wrap, busy-input, back-to-back and reset sequences.
module tb_line_mem_responder;

  logic         clk;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] din;
  logic         is_output_valid;
  logic [127:0] dout;
  logic         mem_ready;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [127:0] din;
    logic [127:0] exp_dout;
  } vec_t;

  vec_t vecs[12];

  line_mem_responder #(
    .BLOCK_SIZE (16),
    .NUM_BLOCKS (16),
    .DELAY      (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .din             (din),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .mem_ready       (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [127:0] d);
    is_input_valid = v;
    mem_read       = rd;
    mem_write      = wr;
    addr           = a;
    din            = d;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!mem_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!mem_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got mem_ready=0 expected 1 within 100 cycles");
    end
  endtask

  // Presents one request and returns 1 time unit after its acceptance edge.
  task automatic send(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [127:0] d, input logic [127:0] exp);
    wait_ready();
    drive(1'b1, rd, wr, a, d);
    if (rd && !wr) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, a, d);
  endtask

  // Scoreboard: every read response pops exactly one expected line.
  always @(negedge clk) begin
    if (!reset && is_output_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: got dout=%h with no pending read", dout);
      end else begin
        check("read_data", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'd5,  {16{8'h55}}, 128'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'd7,  {16{8'h77}}, 128'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'd19, {4{32'h12345678}}, 128'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'd3,  128'h0, {4{32'h12345678}}};
    vecs[4]  = '{1'b0, 1'b1, 32'd6,  128'h0, 128'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'd6,  128'h0, 128'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'd5,  128'h0, {16{8'h55}}};
    vecs[7]  = '{1'b1, 1'b1, 32'd8,  {16{8'hCC}}, 128'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'd8,  128'h0, {16{8'hCC}}};
    vecs[9]  = '{1'b1, 1'b0, 32'd24, 128'h0, {16{8'hCC}}};
    vecs[10] = '{1'b0, 1'b1, 32'd15, {8{16'hBEEF}}, 128'h0};
    vecs[11] = '{1'b1, 1'b0, 32'd31, 128'h0, {8{16'hBEEF}}};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 128'h0);
    #12;
    check("reset_ready", mem_ready, 1'b1);
    check("reset_valid", is_output_valid, 1'b0);
    check("reset_dout", dout, 128'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Write line 3: ready low after E0..E3, high after E4, never a response.
    send(1'b0, 1'b1, 32'd3, {16{8'hA5}}, 128'h0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("wr_ready_e%0d", k), mem_ready, (k == 4));
      check($sformatf("wr_valid_e%0d", k), is_output_valid, 1'b0);
    end

    // Read line 3: one-cycle valid after E4, ready back after E5.
    send(1'b1, 1'b0, 32'd3, 128'h0, {16{8'hA5}});
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("rd_ready_e%0d", k), mem_ready, (k == 5));
      check($sformatf("rd_valid_e%0d", k), is_output_valid, (k == 4));
    end

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].exp_dout);
    end

    // Inputs wiggle while busy: only line 5 comes back, line 7 stays intact.
    wait_ready();
    send(1'b1, 1'b0, 32'd5, 128'h0, {16{8'h55}});
    @(posedge clk); #1; drive(1'b1, 1'b1, 1'b0, 32'd7, 128'h0);
    @(posedge clk); #1; drive(1'b0, 1'b0, 1'b0, 32'd7, 128'h0);
    @(posedge clk); #1; drive(1'b1, 1'b1, 1'b1, 32'd7, {16{8'hEE}});
    @(posedge clk); #1; drive(1'b0, 1'b0, 1'b0, 32'd0, 128'h0);
    repeat (6) @(posedge clk);
    #1;
    check("busy_single_response", 128'(exp_q.size()), 128'd0);
    send(1'b1, 1'b0, 32'd7, 128'h0, {16{8'h77}});

    // Back-to-back with valid held: write 2 then read 2 accepted at E5.
    wait_ready();
    drive(1'b1, 1'b0, 1'b1, 32'd2, 128'd1);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b0, 32'd2, 128'd0);
    exp_q.push_back(128'd1);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_e%0d", k), mem_ready, (k == 4));
    end
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 128'h0);
    @(negedge clk);
    check("b2b_read_accepted", mem_ready, 1'b0);
    for (int k = 6; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("b2b_valid_e%0d", k), is_output_valid, (k == 9));
    end

    // Reset at E2 of a write to line 6 discards it.
    wait_ready();
    send(1'b0, 1'b1, 32'd6, {16{8'hFF}}, 128'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_ready", mem_ready, 1'b1);
    check("midreset_valid", is_output_valid, 1'b0);
    check("midreset_dout", dout, 128'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(1'b1, 1'b0, 32'd6, 128'h0, 128'h0);

    // Valid with neither read nor write is ignored.
    wait_ready();
    drive(1'b1, 1'b0, 1'b0, 32'd9, {16{8'h99}});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("nop_ready_%0d", k), mem_ready, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 128'h0);

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
